// File: rtl/alu_pkg.sv
// Shared ALU constants: default datapath width and the add/subtract mode encoding.
package alu_pkg;
    localparam int   ALU_WIDTH = 16;
    localparam logic MODE_ADD  = 1'b0;
    localparam logic MODE_SUB  = 1'b1;
endpackage

// File: rtl/full_adder.sv
// One bit of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);
endmodule

// File: rtl/twos_complement_adder.sv
// Registered two's-complement adder/subtractor: ripple chain of full adders with
// the sum, carry-out and signed overflow captured one clock after the operands.
module twos_complement_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             M,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);
    logic             w_sub;
    logic [WIDTH-1:0] w_bop;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;
    logic             w_ovf;

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    // Subtract is A + ~B + 1; a borrow-in cancels that +1, hence cin XOR M.
    assign w_sub  = (M == MODE_SUB);
    assign w_bop  = B ^ {WIDTH{w_sub}};
    assign w_c[0] = cin ^ w_sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a  (A[i]),
            .b  (w_bop[i]),
            .ci (w_c[i]),
            .s  (w_sum[i]),
            .co (w_c[i+1])
        );
    end

    assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_c[WIDTH];
            r_ovf  <= w_ovf;
        end
    end

    assign S    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_twos_complement_adder.sv
// Scoreboard bench: the driver pushes model results per issued operation, the
// monitor pops one per clock edge and compares against the registered outputs.
module tb_twos_complement_adder;
    localparam int W = 16;

    typedef struct {
        string      name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic       ci;
        logic       m;
        logic [W-1:0] s;
        logic       co;
        logic       ov;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] A, B;
    logic         cin, M;
    logic [W-1:0] S;
    logic         cout, ovf;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    twos_complement_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .M     (M),
        .S     (S),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(string name, logic [W-1:0] a, logic [W-1:0] b,
                                   logic ci, logic m);
        exp_t e;
        int ua, ub, sa, sb, r, t, c;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = ci ? 1 : 0;
        if (!m) begin
            r    = ua + ub + c;
            t    = sa + sb + c;
            e.co = (r >= 65536);
        end else begin
            r    = ua - ub - c;
            t    = sa - sb - c;
            e.co = (ua >= ub + c);
        end
        e.s    = r[W-1:0];
        e.ov   = (t > 32767) || (t < -32768);
        e.name = name;
        e.a = a; e.b = b; e.ci = ci; e.m = m;
        return e;
    endfunction

    task automatic check_zero(string name);
        checks++;
        if (S !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL %s: got S=%h cout=%b ovf=%b, expected S=0000 cout=0 ovf=0",
                     name, S, cout, ovf);
        end
    endtask

    task automatic issue(string name, logic [W-1:0] a, logic [W-1:0] b, logic ci, logic m);
        @(negedge clk);
        A = a; B = b; cin = ci; M = m;
        sb_q.push_back(model(name, a, b, ci, m));
    endtask

    // Monitor: outputs are new after every edge, so one expected entry per edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (S !== e.s || cout !== e.co || ovf !== e.ov) begin
                    errors++;
                    $display("FAIL %s: A=%h B=%h cin=%b M=%b got S=%h cout=%b ovf=%b, expected S=%h cout=%b ovf=%b",
                             e.name, e.a, e.b, e.ci, e.m, S, cout, ovf, e.s, e.co, e.ov);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        A = 16'h1234; B = 16'hFFFF; cin = 1'b1; M = 1'b1;
        #3;
        check_zero("reset_no_edge");
        @(posedge clk);
        #1;
        check_zero("reset_held_over_edge");

        @(negedge clk);
        rst_n = 1'b1;
        A = 16'h0010; B = 16'h0004; cin = 1'b0; M = 1'b0;
        sb_q.push_back(model("add_basic", 16'h0010, 16'h0004, 1'b0, 1'b0));

        issue("sub_basic",      16'h0010, 16'h0004, 1'b0, 1'b1);
        issue("sub_negative",   16'h0004, 16'h0010, 1'b0, 1'b1);
        issue("add_carry_in",   16'h0010, 16'h0004, 1'b1, 1'b0);
        issue("sub_borrow_in",  16'h0010, 16'h0004, 1'b1, 1'b1);
        issue("add_wrap",       16'hFFFF, 16'h0001, 1'b0, 1'b0);
        issue("add_pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0);
        issue("sub_neg_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1);
        issue("sub_equal_brw",  16'h1234, 16'h1234, 1'b1, 1'b1);
        issue("sub_equal",      16'h1234, 16'h1234, 1'b0, 1'b1);
        issue("add_all_ones",   16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        issue("sub_zero_max",   16'h0000, 16'hFFFF, 1'b1, 1'b1);

        for (int i = 0; i < 150; i++)
            issue("random", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

        // Reset pulse between edges: operands already applied must still be
        // processed by the first edge after release.
        issue("after_reset_pulse", 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_zero("reset_mid_stream");
        #1 rst_n = 1'b1;

        for (int i = 0; i < 100; i++)
            issue("random_post_reset", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

        @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
